fetch_controller: RTL and testbench

Sequences instruction fetch for the pipelined core. Owns the fetch PC and drives the instruction-memory request/grant/response handshake with one request in flight. Presents one fetched instruction at a time to the F/D register and absorbs decode stalls. Handles Execute-stage redirects, including discarding stale responses that are still in flight.

---
 rtl/fetch_controller.sv | 71 +++++++
 tb/tb_fetch_controller.sv | 102 ++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC, runs a single-outstanding imem handshake and holds one fetched instruction for decode
// Ports: clk/rst (sync, active-low); PCSrcE/PCTargetE redirect from Execute; StallD decode back-pressure;
//        imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory handshake; InstrF/PCF/InstrValidF output slot.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        InstrValidF
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, target;
  logic slot_ready, grant, consume, redirect, fill;
  assign target     = {PCTargetE[31:2], 2'b00};
  assign slot_ready = !InstrValidF || !StallD;
  assign imem_req   = (state == REQ) && slot_ready;
  assign imem_addr  = fetch_pc;
  assign grant      = imem_req && imem_gnt;
  assign consume    = InstrValidF && !StallD;
  assign redirect   = PCSrcE && (state != IDLE);
  // a response in WAIT is kept only if no redirect arrives with it
  assign fill       = (state == WAIT) && imem_rvalid && !PCSrcE;
  always_comb begin
    state_n    = state;
    fetch_pc_n = redirect ? target : fill ? fetch_pc + 32'd4 : fetch_pc;
    case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = grant ? (PCSrcE ? KILL : WAIT) : REQ;
      WAIT:    state_n = imem_rvalid ? REQ : PCSrcE ? KILL : WAIT;
      KILL:    state_n = imem_rvalid ? REQ : KILL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      InstrF      <= NOP_INSTR;
      PCF         <= RESET_PC;
      InstrValidF <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (redirect) begin
        InstrValidF <= 1'b0;
        InstrF      <= NOP_INSTR;
      end else if (fill) begin
        InstrValidF <= 1'b1;
        InstrF      <= imem_rdata;
        PCF         <= fetch_pc;
      end else if (consume) begin
        InstrValidF <= 1'b0;
        InstrF      <= NOP_INSTR;
      end
    end
  end
  // requests only go out when the slot can take the answer, so a fill never lands on a held instruction
  a_fill_empty: assert property (@(posedge clk) disable iff (!rst) fill |-> !InstrValidF);
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed-step self-checking bench for fetch_controller
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallD, imem_gnt, imem_rvalid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, InstrValidF;
  logic [31:0] imem_addr, InstrF, PCF;
  int errors = 0;
  int checks = 0;

  fetch_controller dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .InstrValidF(InstrValidF)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, pcs, input logic [31:0] tg, input logic st, g, rv, input logic [31:0] rd);
    @(negedge clk);
    rst = r; PCSrcE = pcs; PCTargetE = tg; StallD = st;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'd0, InstrValidF}, {31'd0, v});
    chk({tag, "_pcf"}, PCF, pc);
    chk({tag, "_instr"}, InstrF, ins);
  endtask

  task automatic req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    slot("rst", 0, 32'h0, 32'h13);
    // release: IDLE this cycle, REQ next
    cyc(1, 0, 0, 0, 1, 0, 0);
    req("idle", 0, 0);
    // free run, 1-cycle memory
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run0", 1, 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 32'hA0);  req("wait0", 0, 0); slot("wait0", 0, 32'h0, 32'h13);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run4", 1, 32'h4); slot("out0", 1, 32'h0, 32'hA0);
    cyc(1, 0, 0, 0, 0, 1, 32'hA4);  slot("gap4", 0, 32'h0, 32'h13);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run8", 1, 32'h8); slot("out4", 1, 32'h4, 32'hA4);
    cyc(1, 0, 0, 0, 0, 1, 32'hA8);
    // decode stall for three cycles holding PCF=8
    cyc(1, 0, 0, 1, 1, 0, 0);       req("stall1", 0, 0); slot("stall1", 1, 32'h8, 32'hA8);
    cyc(1, 0, 0, 1, 1, 0, 0);       req("stall2", 0, 0); slot("stall2", 1, 32'h8, 32'hA8);
    cyc(1, 0, 0, 1, 1, 0, 0);       req("stall3", 0, 0); slot("stall3", 1, 32'h8, 32'hA8);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("runC", 1, 32'hC); slot("out8", 1, 32'h8, 32'hA8);
    cyc(1, 0, 0, 0, 0, 1, 32'hAC);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run10", 1, 32'h10); slot("outC", 1, 32'hC, 32'hAC);
    // redirect in WAIT, stale response two cycles later
    cyc(1, 1, 32'h100, 0, 0, 0, 0); req("redir_w", 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);       req("kill1", 0, 0); chk("kill1_addr", imem_addr, 32'h100);
    cyc(1, 0, 0, 0, 0, 1, 32'hDEAD); slot("kill2", 0, 32'hC, 32'h13);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run100", 1, 32'h100); slot("nodead", 0, 32'hC, 32'h13);
    // redirect together with rvalid in WAIT
    cyc(1, 1, 32'h200, 0, 0, 1, 32'hBEEF);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run200", 1, 32'h200); slot("nobeef", 0, 32'hC, 32'h13);
    // two redirects while killing; low bits of the target are dropped
    cyc(1, 1, 32'h300, 0, 0, 0, 0);
    cyc(1, 1, 32'h405, 0, 0, 0, 0); req("kill404", 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h5555);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("run404", 1, 32'h404); slot("no5555", 0, 32'hC, 32'h13);
    cyc(1, 0, 0, 0, 0, 1, 32'h77);
    // redirect beats a stalled valid slot
    cyc(1, 1, 32'h500, 1, 0, 0, 0); req("stallv", 0, 0); slot("out404", 1, 32'h404, 32'h77);
    cyc(1, 0, 0, 1, 1, 0, 0);       req("run500", 1, 32'h500); slot("cleared", 0, 32'h404, 32'h13);
    // reset mid-transaction, then a late response
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'hBAD); req("rst2", 0, 0); chk("rst2_addr", imem_addr, 32'h0);
    slot("rst2", 0, 32'h0, 32'h13);
    cyc(1, 0, 0, 0, 0, 1, 32'hBAD); req("late", 1, 32'h0); slot("late", 0, 32'h0, 32'h13);
    cyc(1, 0, 0, 0, 0, 0, 0);       req("late2", 1, 32'h0); slot("late2", 0, 32'h0, 32'h13);
    // wrap of fetch_pc + 4
    cyc(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);       req("runFFC", 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 1, 32'h99);
    cyc(1, 0, 0, 0, 0, 0, 0);       req("wrap", 1, 32'h0); slot("outFFC", 1, 32'hFFFF_FFFC, 32'h99);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
